// File: rtl/mc_trace_buf_if.sv
// Trace buffer port bundle: commit stream, session control, read-back and status.
interface mc_trace_buf_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              commit_valid;
    logic [DW-1:0]     commit_pc;
    logic [DW-1:0]     commit_instr;
    logic              arm;
    logic              stop;
    logic              mode_wrap;
    logic              trig_en;
    logic [DW-1:0]     trig_pc;
    logic [AW-1:0]     rd_sel;
    logic [2*DW-1:0]   rd_data;
    logic [AW:0]       count;
    logic [1:0]        state;
    logic              overflow;

    modport master (
        output commit_valid, commit_pc, commit_instr,
        output arm, stop, mode_wrap, trig_en, trig_pc, rd_sel,
        input  rd_data, count, state, overflow
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr,
        input  arm, stop, mode_wrap, trig_en, trig_pc, rd_sel,
        output rd_data, count, state, overflow
    );
endinterface

// File: rtl/mc_trace_buf.sv
// Instruction-retire trace buffer: optional PC trigger, stop-when-full or circular
// capture, and a registered logical-index read port (index 0 = oldest entry).
module mc_trace_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic           clk,
    input  logic           rstn,
    mc_trace_buf_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 2 * DW;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
    localparam logic [1:0] ST_CAPTURE   = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];

    logic [1:0]      state_q,     state_d;
    logic [CW-1:0]   count_q,     count_d;
    logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic            overflow_q,  overflow_d;
    logic            mode_wrap_q, mode_wrap_d;
    logic [DW-1:0]   trig_pc_q,   trig_pc_d;
    logic [EW-1:0]   rd_data_q,   rd_data_d;
    logic            wr_en;
    entry_t          wr_entry;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   rd_idx;
    logic            rd_hit;
    logic            trig_hit;
    logic            room;

    // Session state register and capture bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            mode_wrap_q <= 1'b0;
            trig_pc_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            mode_wrap_q <= mode_wrap_d;
            trig_pc_q   <= trig_pc_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign trig_hit = bus.commit_valid && (bus.commit_pc == trig_pc_q);
    assign room     = mode_wrap_q || (count_q != FULL);

    // Next-state: arm overrides everything, including a same-cycle commit or stop.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        mode_wrap_d = mode_wrap_q;
        trig_pc_d   = trig_pc_q;
        wr_en       = 1'b0;

        if (bus.arm) begin
            state_d     = bus.trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
            count_d     = '0;
            wr_ptr_d    = '0;
            overflow_d  = 1'b0;
            mode_wrap_d = bus.mode_wrap;
            trig_pc_d   = bus.trig_pc;
        end else begin
            case (state_q)
                ST_WAIT_TRIG: begin
                    // The triggering commit itself becomes entry 0.
                    if (trig_hit) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + CW'(1);
                        state_d  = ST_CAPTURE;
                    end
                    if (bus.stop) begin
                        state_d = ST_DONE;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.commit_valid && room) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (count_q == FULL) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                        if (!mode_wrap_q && (count_q == FULL - CW'(1))) begin
                            state_d = ST_DONE;
                        end
                    end
                    if (bus.stop) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    always_comb begin
        oldest    = (count_q == FULL) ? wr_ptr_q : '0;
        rd_idx    = oldest + bus.rd_sel;
        rd_hit    = (CW'(bus.rd_sel) < count_q);
        rd_data_d = rd_hit ? EW'(mem[rd_idx]) : '0;
    end

    assign wr_entry = '{pc: bus.commit_pc, instr: bus.commit_instr};

    // Storage is not reset; entries beyond count are masked on read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.rd_data  = rd_data_q;
endmodule
